mskaes_core_arbiter: RTL and testbench
======================================

MSKAES_CORE_ARBITER -- requirements
Module: mskaes_core_arbiter

Interface
REQ-001 Parameter: d, 2, number of shares per masked bit.
REQ-002 Ports: clk  in  1  clock; nrst  in  1  reset, synchronous, active-low.
REQ-003 Ports: req0_valid / req1_valid  in  1  requester i has a block pending.
REQ-004 Ports: req0_ready / req1_ready  out  1  block from requester i accepted this cycle.
REQ-005 Ports: req0_sh_plaintext, req0_sh_key, req1_sh_plaintext, req1_sh_key  in  128*d  shared operands.
REQ-006 Ports: core_valid_in  out  1; core_ready  in  1; core_cipher_valid  in  1  masked AES core handshake.
REQ-007 Ports: core_sh_plaintext, core_sh_key  out  128*d; core_sh_ciphertext  in  128*d.
REQ-008 Ports: rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  1  originating requester; rsp_sh_ciphertext  out  128*d.

Function
REQ-009 FSM states IDLE, BUSY, HOLD; one block in flight at most.
REQ-010 IDLE: if core_ready and (req0_valid or req1_valid), grant one requester, assert core_valid_in and that requester's reqi_ready combinationally in the same cycle, then go to BUSY; otherwise stay in IDLE.
REQ-011 Grant decision follows REQ-024/REQ-025.
REQ-012 Register the granted requester id at the accept edge; it is held until the response is consumed.
REQ-013 core_sh_plaintext and core_sh_key equal the granted requester's shares during the accept cycle; at all other times they equal the all-zero sharing.
REQ-014 Non-granted reqi_ready = 0; req*_ready = 0 outside IDLE.
REQ-015 BUSY: on core_cipher_valid = 1, capture core_sh_ciphertext into the response buffer and go to HOLD; otherwise stay in BUSY.
REQ-016 HOLD: rsp_valid = 1, rsp_id = registered id, rsp_sh_ciphertext = buffer; on rsp_ready = 1 clear the buffer to zero and go to IDLE.
REQ-017 A new block is issued no earlier than the cycle after the rsp_valid & rsp_ready handshake.
REQ-018 rsp_sh_ciphertext is the all-zero sharing whenever rsp_valid = 0.
REQ-019 core_cipher_valid in IDLE or HOLD is ignored.
REQ-020 Requester inputs are sampled only in the accept cycle; requesters hold valid and data stable until ready.
REQ-021 Shares are moved only by muxes and registers; no logic combines shares.

Reset
REQ-022 nrst = 0 at a clock edge: state IDLE, buffer zero, id 0, round-robin pointer at its reset value; this applies even mid-operation, and any in-flight result is discarded.
REQ-023 Outputs during and immediately after reset: rsp_valid = 0, core_valid_in = 0, req*_ready = 0, all share outputs zero.

Configuration
REQ-024 MSKAES_ARB_ROUND_ROBIN_EN defined: when both requesters are valid, grant the one not granted last; the last-grant pointer resets to 1, so requester 0 wins the first tie; a single valid requester is always granted.
REQ-025 MSKAES_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins; the pointer is not implemented.

Verification
REQ-026 Test 1: req0 only, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff (random shares); rsp_ready = 1. Required: rsp_valid pulses once with rsp_id = 0; recombined ct = 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-027 Test 2: both requesters valid continuously for 4 blocks. With the macro defined, grant order is 0,1,0,1. Without it, grant order is 0,0,0,0 and req1_ready stays 0.
REQ-028 Test 3: rsp_ready held at 0 for 20 cycles after rsp_valid. Required: buffer stable, core_valid_in = 0, no req*_ready; the next grant occurs the cycle after rsp_ready goes to 1.
REQ-029 Test 4: nrst pulsed during BUSY. Required: next cycle IDLE, rsp_valid = 0, all outputs zero; the late core_cipher_valid is ignored.
REQ-030 Test 5: core_ready = 0 with req0_valid = 1. Required: no grant and core_valid_in = 0; the grant occurs in the first cycle core_ready = 1.
REQ-031 Test 6: all share outputs checked for the all-zero sharing whenever the corresponding valid or accept condition is inactive.

Source files
------------

// File: rtl/mskaes_core_arbiter.sv
// mskaes_core_arbiter: two-requester front end for one masked AES core.
// Grants one block at a time, tracks its owner, buffers the masked result.
//
// Ports
//   clk, nrst               clock, synchronous active-low reset
//   reqN_valid/reqN_ready   requester N handshake (ready = accepted now)
//   reqN_sh_plaintext/key   requester N shared operands, 128*d bits
//   core_valid_in           block presented to the core this cycle
//   core_ready              core can take a block
//   core_cipher_valid       core result strobe
//   core_sh_plaintext/key   shares forwarded to the core
//   core_sh_ciphertext      shared result from the core
//   rsp_valid/rsp_ready     response handshake
//   rsp_id                  requester that owns the response
//   rsp_sh_ciphertext       buffered shared result
//
// Build option
//   MSKAES_ARB_ROUND_ROBIN_EN  alternate grants on ties
//                              (default: requester 0 has priority)
//
// Share i occupies bits [128*i +: 128] of every shared bus.
// Shares only pass through muxes and registers; they are never combined.

module mskaes_core_arbiter #(
   parameter int d = 2
) (
   input  logic             clk,
   input  logic             nrst,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [128*d-1:0] req0_sh_plaintext,
   input  logic [128*d-1:0] req0_sh_key,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [128*d-1:0] req1_sh_plaintext,
   input  logic [128*d-1:0] req1_sh_key,

   output logic             core_valid_in,
   input  logic             core_ready,
   input  logic             core_cipher_valid,
   output logic [128*d-1:0] core_sh_plaintext,
   output logic [128*d-1:0] core_sh_key,
   input  logic [128*d-1:0] core_sh_ciphertext,

   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [128*d-1:0] rsp_sh_ciphertext
);

   localparam int W = 128 * d;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;

   logic           r_id;
   logic [W-1:0]   r_ct;

   logic           w_any;
   logic           w_gnt1;
   logic           w_accept;
   logic           w_capture;
   logic           w_release;
   logic           w_hold;

   assign w_any = req0_valid | req1_valid;

   // ---------------------------------------------------------
   // Grant selection
   // ---------------------------------------------------------
`ifdef MSKAES_ARB_ROUND_ROBIN_EN
   // r_last is the requester granted most recently; reset to 1
   // so requester 0 wins the first tie.
   logic r_last;

   always_comb begin
      w_gnt1 = req1_valid & (~req0_valid | ~r_last);
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_last <= 1'b1;
      end else if (w_accept) begin
         r_last <= w_gnt1;
      end
   end
`else
   always_comb begin
      w_gnt1 = req1_valid & ~req0_valid;
   end
`endif

   // ---------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------
   // FSM: next state and strobes
   // Strobes are qualified with nrst so nothing is granted or
   // presented while reset is held, whatever the old state.
   // ---------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_release   = 1'b0;
      w_hold      = 1'b0;
      if (nrst) begin
         unique case (r_state)
            IDLE: begin
               if (core_ready && w_any) begin
                  w_accept    = 1'b1;
                  w_state_nxt = BUSY;
               end
            end
            BUSY: begin
               if (core_cipher_valid) begin
                  w_capture   = 1'b1;
                  w_state_nxt = HOLD;
               end
            end
            HOLD: begin
               w_hold = 1'b1;
               if (rsp_ready) begin
                  w_release   = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------
   // Owner id and response buffer
   // ---------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_id <= 1'b0;
         r_ct <= '0;
      end else begin
         if (w_accept) begin
            r_id <= w_gnt1;
         end
         if (w_capture) begin
            r_ct <= core_sh_ciphertext;
         end else if (w_release) begin
            r_ct <= '0;
         end
      end
   end

   // ---------------------------------------------------------
   // Requester and core side
   // ---------------------------------------------------------
   assign core_valid_in = w_accept;
   assign req0_ready    = w_accept & ~w_gnt1;
   assign req1_ready    = w_accept &  w_gnt1;

   // Operands reach the core only in the accept cycle; the
   // all-zero sharing is driven otherwise.
   always_comb begin
      core_sh_plaintext = '0;
      core_sh_key       = '0;
      if (w_accept) begin
         if (w_gnt1) begin
            core_sh_plaintext = req1_sh_plaintext;
            core_sh_key       = req1_sh_key;
         end else begin
            core_sh_plaintext = req0_sh_plaintext;
            core_sh_key       = req0_sh_key;
         end
      end
   end

   // ---------------------------------------------------------
   // Response side
   // ---------------------------------------------------------
   assign rsp_valid = w_hold;
   assign rsp_id    = r_id;

   always_comb begin
      rsp_sh_ciphertext = '0;
      if (w_hold) begin
         rsp_sh_ciphertext = r_ct;
      end
   end

endmodule

// File: tb/tb_mskaes_core_arbiter.sv
// tb_mskaes_core_arbiter: directed bench for mskaes_core_arbiter.
// The bench plays both requesters, the AES core and the consumer.

module tb_mskaes_core_arbiter;

   localparam int d = 2;
   localparam int W = 128 * d;

   logic         clk = 1'b0;
   logic         nrst;
   logic         req0_valid, req0_ready;
   logic [W-1:0] req0_sh_plaintext, req0_sh_key;
   logic         req1_valid, req1_ready;
   logic [W-1:0] req1_sh_plaintext, req1_sh_key;
   logic         core_valid_in, core_ready, core_cipher_valid;
   logic [W-1:0] core_sh_plaintext, core_sh_key, core_sh_ciphertext;
   logic         rsp_valid, rsp_ready, rsp_id;
   logic [W-1:0] rsp_sh_ciphertext;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mskaes_core_arbiter #(.d(d)) dut (
      .clk                (clk),
      .nrst               (nrst),
      .req0_valid         (req0_valid),
      .req0_ready         (req0_ready),
      .req0_sh_plaintext  (req0_sh_plaintext),
      .req0_sh_key        (req0_sh_key),
      .req1_valid         (req1_valid),
      .req1_ready         (req1_ready),
      .req1_sh_plaintext  (req1_sh_plaintext),
      .req1_sh_key        (req1_sh_key),
      .core_valid_in      (core_valid_in),
      .core_ready         (core_ready),
      .core_cipher_valid  (core_cipher_valid),
      .core_sh_plaintext  (core_sh_plaintext),
      .core_sh_key        (core_sh_key),
      .core_sh_ciphertext (core_sh_ciphertext),
      .rsp_valid          (rsp_valid),
      .rsp_ready          (rsp_ready),
      .rsp_id             (rsp_id),
      .rsp_sh_ciphertext  (rsp_sh_ciphertext)
   );

   task automatic chk1(input string tag, input logic obs,
                       input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] share(input logic [127:0] v);
      logic [W-1:0] s;
      logic [127:0] acc;
      acc = v;
      for (int i = 1; i < d; i++) begin
         s[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
         acc ^= s[128*i +: 128];
      end
      s[127:0] = acc;
      return s;
   endfunction

   function automatic logic [127:0] recomb(input logic [W-1:0] s);
      logic [127:0] acc;
      acc = '0;
      for (int i = 0; i < d; i++) acc ^= s[128*i +: 128];
      return acc;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // no grant and the all-zero sharing towards the core
   task automatic chk_quiet(input string tag);
      chk1({tag, ".core_valid_in"}, core_valid_in, 1'b0);
      chk1({tag, ".req0_ready"}, req0_ready, 1'b0);
      chk1({tag, ".req1_ready"}, req1_ready, 1'b0);
      chkw({tag, ".core_pt"}, core_sh_plaintext, '0);
      chkw({tag, ".core_key"}, core_sh_key, '0);
   endtask

   task automatic chk_noresp(input string tag);
      chk1({tag, ".rsp_valid"}, rsp_valid, 1'b0);
      chkw({tag, ".rsp_ct"}, rsp_sh_ciphertext, '0);
   endtask

   task automatic chk_accept(input string tag, input logic id,
                             input logic [W-1:0] pt,
                             input logic [W-1:0] key);
      chk1({tag, ".core_valid_in"}, core_valid_in, 1'b1);
      chk1({tag, ".req0_ready"}, req0_ready, ~id);
      chk1({tag, ".req1_ready"}, req1_ready, id);
      chkw({tag, ".core_pt"}, core_sh_plaintext, pt);
      chkw({tag, ".core_key"}, core_sh_key, key);
   endtask

   logic [127:0] key1, pt1, ct1;
   logic [W-1:0] p0, k0, p1, k1, cts, junk;
   logic         exp_id;

   initial begin
      key1 = 128'h000102030405060708090a0b0c0d0e0f;
      pt1  = 128'h00112233445566778899aabbccddeeff;
      ct1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

      nrst = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_sh_plaintext = '0; req0_sh_key = '0;
      req1_sh_plaintext = '0; req1_sh_key = '0;
      core_ready = 1'b0; core_cipher_valid = 1'b0;
      core_sh_ciphertext = '0; rsp_ready = 1'b0;

      // reset, with a request pending that must not be granted
      #2;
      req0_valid = 1'b1;
      core_ready = 1'b1;
      #1;
      chk_quiet("rst0");
      chk_noresp("rst0");
      cyc();
      chk_quiet("rst1");
      chk_noresp("rst1");
      cyc();
      req0_valid = 1'b0;
      nrst = 1'b1;
      #2;
      chk_quiet("post_rst");
      chk_noresp("post_rst");
      chk1("post_rst.rsp_id", rsp_id, 1'b0);

      // test 1: single block from requester 0
      p0 = share(pt1);
      k0 = share(key1);
      cyc();
      req0_sh_plaintext = p0;
      req0_sh_key = k0;
      req0_valid = 1'b1;
      rsp_ready = 1'b1;
      #2;
      chk_accept("t1.acc", 1'b0, p0, k0);
      chk_noresp("t1.acc");
      cyc();
      req0_valid = 1'b0;
      cts = share(ct1);
      core_sh_ciphertext = cts;
      core_cipher_valid = 1'b1;
      #2;
      chk_quiet("t1.busy");
      chk_noresp("t1.busy");
      cyc();
      core_cipher_valid = 1'b0;
      core_sh_ciphertext = share(128'h0);
      #2;
      chk1("t1.rsp_valid", rsp_valid, 1'b1);
      chk1("t1.rsp_id", rsp_id, 1'b0);
      chkw("t1.rsp_ct", rsp_sh_ciphertext, cts);
      chkw("t1.recomb", {128'h0, recomb(rsp_sh_ciphertext)},
           {128'h0, ct1});
      cyc();
      #2;
      chk_noresp("t1.done");
      chk_quiet("t1.done");

      // test 2: both requesters valid for four blocks
      nrst = 1'b0;
      cyc();
      nrst = 1'b1;
      p0 = share(128'h0123456789abcdeffedcba9876543210);
      k0 = share(128'h11111111111111111111111111111111);
      p1 = share(128'hdeadbeefcafef00d0badc0de12345678);
      k1 = share(128'h22222222222222222222222222222222);
      req0_sh_plaintext = p0; req0_sh_key = k0;
      req1_sh_plaintext = p1; req1_sh_key = k1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      rsp_ready = 1'b1;
      #2;
      for (int b = 0; b < 4; b++) begin
`ifdef MSKAES_ARB_ROUND_ROBIN_EN
         exp_id = b[0];
`else
         exp_id = 1'b0;
`endif
         if (exp_id) chk_accept("t2.acc", 1'b1, p1, k1);
         else        chk_accept("t2.acc", 1'b0, p0, k0);
         cyc();
         cts = share({$urandom, $urandom, $urandom, $urandom});
         core_sh_ciphertext = cts;
         core_cipher_valid = 1'b1;
         #2;
         chk_quiet("t2.busy");
         chk_noresp("t2.busy");
         cyc();
         core_cipher_valid = 1'b0;
         core_sh_ciphertext = '0;
         #2;
         chk1("t2.rsp_valid", rsp_valid, 1'b1);
         chk1("t2.rsp_id", rsp_id, exp_id);
         chkw("t2.rsp_ct", rsp_sh_ciphertext, cts);
         chk_quiet("t2.hold");
         cyc();
         #2;
      end

      // test 3: consumer stalls for 20 cycles
      req1_valid = 1'b0;
      #1;
      chk_accept("t3.acc", 1'b0, p0, k0);
      cyc();
      req0_valid = 1'b0;
      cts = share(128'h5a5a5a5a0f0f0f0fa5a5a5a5f0f0f0f0);
      core_sh_ciphertext = cts;
      core_cipher_valid = 1'b1;
      cyc();
      core_cipher_valid = 1'b0;
      rsp_ready = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #2;
      chk1("t3.rsp_valid", rsp_valid, 1'b1);
      chkw("t3.rsp_ct", rsp_sh_ciphertext, cts);
      for (int i = 0; i < 20; i++) begin
         cyc();
         junk = share({$urandom, $urandom, $urandom, $urandom});
         core_sh_ciphertext = junk;
         core_cipher_valid = 1'b1;
         #2;
         chk1("t3.stall.rsp_valid", rsp_valid, 1'b1);
         chkw("t3.stall.rsp_ct", rsp_sh_ciphertext, cts);
         chk_quiet("t3.stall");
      end
      cyc();
      core_cipher_valid = 1'b0;
      rsp_ready = 1'b1;
      #2;
      chk1("t3.hs.rsp_valid", rsp_valid, 1'b1);
      chk_quiet("t3.hs");
      cyc();
      #2;
      chk_noresp("t3.after");
`ifdef MSKAES_ARB_ROUND_ROBIN_EN
      chk_accept("t3.regrant", 1'b1, p1, k1);
`else
      chk_accept("t3.regrant", 1'b0, p0, k0);
`endif

      // test 4: reset while BUSY, late result ignored
      cyc();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      nrst = 1'b0;
      #2;
      chk_quiet("t4.inrst");
      chk_noresp("t4.inrst");
      cyc();
      nrst = 1'b1;
      core_sh_ciphertext = share(128'hffeeddccbbaa99887766554433221100);
      core_cipher_valid = 1'b1;
      #2;
      chk_quiet("t4.idle");
      chk_noresp("t4.idle");
      chk1("t4.rsp_id", rsp_id, 1'b0);
      cyc();
      core_cipher_valid = 1'b0;
      #2;
      chk_noresp("t4.late");
      chk_quiet("t4.late");

      // test 5: core not ready
      core_ready = 1'b0;
      req0_valid = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk_quiet("t5.wait");
         cyc();
         #2;
      end
      chk_quiet("t5.wait");
      cyc();
      core_ready = 1'b1;
      #2;
      chk_accept("t5.acc", 1'b0, p0, k0);
      cyc();
      req0_valid = 1'b0;
      cts = share(128'h13579bdf2468ace013579bdf2468ace0);
      core_sh_ciphertext = cts;
      core_cipher_valid = 1'b1;
      cyc();
      core_cipher_valid = 1'b0;
      #2;
      chk1("t5.rsp_valid", rsp_valid, 1'b1);
      chk1("t5.rsp_id", rsp_id, 1'b0);
      chkw("t5.rsp_ct", rsp_sh_ciphertext, cts);
      cyc();
      #2;
      chk_noresp("t5.done");
      chk_quiet("t5.done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
